// File: rtl/lap_bank_ctrl.sv
//------------------------------------------------------------------------------
// lap_bank_ctrl : write-strobe, browse-address and fill tracking for the
//                 16 x 24-bit lap register bank and its registered readout mux.
// Option macro  : LAP_RING_EN (overwrite the oldest lap when full)
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lap_bank_ctrl (
  input  logic        rclk,
  input  logic        rst_n,
  input  logic        lap,
  input  logic        clear,
  input  logic        next,
  input  logic        prev,
  output logic [15:0] wr_en,
  output logic [3:0]  rd_addr,
  output logic [4:0]  count,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        out_valid
);

  localparam logic [1:0] c_SETTLE_LAP    = 2'd2;
  localparam logic [1:0] c_SETTLE_BROWSE = 2'd1;

  logic [3:0]  r_wr_ptr, r_oldest, r_rd_idx;
  logic [1:0]  r_settle;

  logic [3:0]  w_wr_ptr, w_oldest, w_rd_idx, w_last;
  logic [4:0]  w_count;
  logic [1:0]  w_settle;
  logic [15:0] w_wr_en;
  logic        w_overflow;

  // Browse position of the newest lap; wraps to 15 when count is 16.
  assign w_last = 4'(count - 5'd1);

  always_comb begin
    w_wr_ptr   = r_wr_ptr;
    w_oldest   = r_oldest;
    w_rd_idx   = r_rd_idx;
    w_count    = count;
    w_overflow = overflow;
    w_wr_en    = '0;
    w_settle   = (r_settle != 2'd0) ? r_settle - 2'd1 : 2'd0;

    if (clear) begin
      w_wr_ptr   = '0;
      w_oldest   = '0;
      w_rd_idx   = '0;
      w_count    = '0;
      w_overflow = 1'b0;
      w_settle   = '0;
    end else if (lap) begin
      if (!full) begin
        w_wr_en  = 16'h0001 << r_wr_ptr;
        w_wr_ptr = r_wr_ptr + 4'd1;
        w_count  = count + 5'd1;
        w_rd_idx = count[3:0];
        w_settle = c_SETTLE_LAP;
      end else begin
`ifdef LAP_RING_EN
        w_wr_en  = 16'h0001 << r_wr_ptr;
        w_wr_ptr = r_wr_ptr + 4'd1;
        w_oldest = r_oldest + 4'd1;
        w_rd_idx = 4'd15;
        w_settle = c_SETTLE_LAP;
`else
        w_overflow = 1'b1;
`endif
      end
    end else if ((next ^ prev) && (count != 5'd0)) begin
      if (next)
        w_rd_idx = (r_rd_idx == w_last) ? 4'd0 : r_rd_idx + 4'd1;
      else
        w_rd_idx = (r_rd_idx == 4'd0) ? w_last : r_rd_idx - 4'd1;
      w_settle = c_SETTLE_BROWSE;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_oldest  <= '0;
      r_rd_idx  <= '0;
      r_settle  <= '0;
      wr_en     <= '0;
      rd_addr   <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr;
      r_oldest  <= w_oldest;
      r_rd_idx  <= w_rd_idx;
      r_settle  <= w_settle;
      wr_en     <= w_wr_en;
      rd_addr   <= w_oldest + w_rd_idx;
      count     <= w_count;
      empty     <= (w_count == 5'd0);
      full      <= (w_count == 5'd16);
      overflow  <= w_overflow;
      out_valid <= (w_count != 5'd0) && (w_settle == 2'd0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lap_bank_ctrl.sv
//------------------------------------------------------------------------------
// tb_lap_bank_ctrl : directed self-checking bench for lap_bank_ctrl.
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lap_bank_ctrl;

  logic        rclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lap = 1'b0, clear = 1'b0, next = 1'b0, prev = 1'b0;
  logic [15:0] wr_en;
  logic [3:0]  rd_addr;
  logic [4:0]  count;
  logic        empty, full, overflow, out_valid;

  int passed = 0;
  int total  = 0;

  lap_bank_ctrl dut (
    .rclk      (rclk),
    .rst_n     (rst_n),
    .lap       (lap),
    .clear     (clear),
    .next      (next),
    .prev      (prev),
    .wr_en     (wr_en),
    .rd_addr   (rd_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the capturing edge.
  task automatic pulse(input logic l, input logic c, input logic n, input logic p);
    lap = l; clear = c; next = n; prev = p;
    @(posedge rclk); #1;
    lap = 0; clear = 0; next = 0; prev = 0;
  endtask

  task automatic idle();
    pulse(0, 0, 0, 0);
  endtask

  logic [3:0] browse_exp [4];

  initial begin
    browse_exp[0] = 4'd0; browse_exp[1] = 4'd1;
    browse_exp[2] = 4'd0; browse_exp[3] = 4'd2;

    // Reset state
    #12;
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    @(negedge rclk); rst_n = 1'b1;
    @(posedge rclk); #1;

    // Three laps four cycles apart
    for (int i = 0; i < 3; i++) begin
      pulse(1, 0, 0, 0);
      chk("lap_wr_en", 32'(wr_en), 32'h1 << i);
      chk("lap_count", 32'(count), 32'(i + 1));
      chk("lap_rd_addr", 32'(rd_addr), 32'(i));
      chk("lap_ov_n", 32'(out_valid), 32'h0);
      idle();
      chk("lap_wr_en_drop", 32'(wr_en), 32'h0);
      chk("lap_ov_n1", 32'(out_valid), 32'h0);
      idle();
      chk("lap_ov_n2", 32'(out_valid), 32'h1);
      idle();
    end

    // Browse: next, next, prev, prev
    for (int i = 0; i < 4; i++) begin
      pulse(0, 0, i < 2, i >= 2);
      chk("browse_rd_addr", 32'(rd_addr), 32'(browse_exp[i]));
      chk("browse_ov_n", 32'(out_valid), 32'h0);
      idle();
      chk("browse_ov_n1", 32'(out_valid), 32'h1);
    end

    // Fill to 16
    for (int i = 3; i < 16; i++) begin
      pulse(1, 0, 0, 0);
      chk("fill_wr_en", 32'(wr_en), 32'h1 << i);
    end
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_rd_addr", 32'(rd_addr), 32'd15);
    idle(); idle();

    // 17th lap
    pulse(1, 0, 0, 0);
`ifdef LAP_RING_EN
    chk("ring_wr_en", 32'(wr_en), 32'h0001);
    chk("ring_rd_addr", 32'(rd_addr), 32'h0);
    chk("ring_count", 32'(count), 32'd16);
    chk("ring_overflow", 32'(overflow), 32'h0);
    chk("ring_oldest", 32'(dut.r_oldest), 32'h1);
`else
    chk("drop_wr_en", 32'(wr_en), 32'h0);
    chk("drop_overflow", 32'(overflow), 32'h1);
    chk("drop_full", 32'(full), 32'h1);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_rd_addr", 32'(rd_addr), 32'd15);
    idle();
    chk("drop_overflow_sticky", 32'(overflow), 32'h1);
`endif
    idle();

    // clear wins over lap and next
    pulse(1, 1, 1, 0);
    chk("clr_wr_en", 32'(wr_en), 32'h0);
    chk("clr_count", 32'(count), 32'h0);
    chk("clr_empty", 32'(empty), 32'h1);
    chk("clr_rd_addr", 32'(rd_addr), 32'h0);
    chk("clr_overflow", 32'(overflow), 32'h0);
    chk("clr_out_valid", 32'(out_valid), 32'h0);

    // Browsing an empty bank
    pulse(0, 0, 1, 0);
    chk("empty_next_rd_addr", 32'(rd_addr), 32'h0);
    chk("empty_next_ov", 32'(out_valid), 32'h0);
    pulse(0, 0, 0, 1);
    chk("empty_prev_rd_addr", 32'(rd_addr), 32'h0);
    chk("empty_prev_ov", 32'(out_valid), 32'h0);

    // lap beats next
    pulse(1, 0, 1, 0);
    chk("lapnext_wr_en", 32'(wr_en), 32'h0001);
    chk("lapnext_rd_addr", 32'(rd_addr), 32'h0);
    chk("lapnext_count", 32'(count), 32'h1);
    idle(); idle();

    // Async reset while the second lap's strobe is high
    pulse(1, 0, 0, 0);
    chk("mid_wr_en", 32'(wr_en), 32'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk("async_wr_en", 32'(wr_en), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    chk("async_rd_addr", 32'(rd_addr), 32'h0);
    @(negedge rclk); rst_n = 1'b1;
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
